// File: rtl/reg_writeback_pkg.sv
// Shared types and defaults for the LC-3b register file write-back sequencer.
package reg_writeback_pkg;

  localparam int WB_WIDTH  = 16;
  localparam int WB_DEPTH  = 4;
  localparam int REG_IDX_W = 3;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t            dr;
    logic [WB_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_writeback_if.sv
// Result handshake from the datapath plus the register file write port.
interface reg_writeback_if
  import reg_writeback_pkg::*;
#(
  parameter int WIDTH = WB_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  reg_idx_t         in_dr;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] bus;
  logic             WE;
  reg_idx_t         DR;

  modport master (
    output in_valid, in_dr, in_data,
    input  in_ready, bus, WE, DR
  );

  modport slave (
    input  in_valid, in_dr, in_data,
    output in_ready, bus, WE, DR
  );

endinterface

// File: rtl/reg_writeback_wb_queue.sv
// Circular FIFO of pending {dr, data} writes; exposes every slot so the top
// level can scan for hazards without a second copy of the storage.
module wb_queue
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int WIDTH = WB_WIDTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  reg_idx_t         push_dr,
  input  logic [WIDTH-1:0] push_data,
  output reg_idx_t         ent_dr   [DEPTH],
  output logic [WIDTH-1:0] ent_data [DEPTH],
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  reg_idx_t         dr_r   [DEPTH];
  logic [WIDTH-1:0] data_r [DEPTH];
  logic             push_ok_s;
  logic             pop_ok_s;

  // Never overfill or underflow, whatever the caller asks for.
  always_comb begin
    push_ok_s = push & (count_r != CNT_W'(DEPTH));
    pop_ok_s  = pop & (count_r != {CNT_W{1'b0}});
  end

  // Pointers, occupancy and storage; flush drops pending entries but keeps data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dr_r[i]   <= '0;
        data_r[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        dr_r[wr_ptr_r]   <= push_dr;
        data_r[wr_ptr_r] <= push_data;
        wr_ptr_r         <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign ent_dr   = dr_r;
  assign ent_data = data_r;
  assign rd_ptr   = rd_ptr_r;
  assign count    = count_r;

endmodule

// File: rtl/reg_writeback.sv
// Write-side sequencer for the 8x16 register file: buffers results, drives the
// write port one entry per cycle and flags/forwards pending writes to the readers.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int WIDTH = WB_WIDTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  reg_writeback_if.slave   wb,
  input  logic             stall,
  input  logic             flush,
  input  reg_idx_t         SR1,
  input  reg_idx_t         SR2,
  output logic             hazA,
  output logic             hazB,
  output logic [WIDTH-1:0] fwdA,
  output logic [WIDTH-1:0] fwdB,
  output logic [CNT_W-1:0] count
);

  reg_idx_t         ent_dr_s   [DEPTH];
  logic [WIDTH-1:0] ent_data_s [DEPTH];
  logic [PTR_W-1:0] rd_ptr_s;
  logic [CNT_W-1:0] count_s;
  logic             ready_s;
  logic             we_s;
  logic             push_s;
  logic [WIDTH-1:0] bus_s;
  reg_idx_t         dr_s;
  logic [WIDTH:0]   match_a_s;
  logic [WIDTH:0]   match_b_s;

  // Walk oldest to youngest so the last hit is the youngest pending value.
  function automatic logic [WIDTH:0] youngest_match(
    input reg_idx_t         sel,
    input reg_idx_t         drs   [DEPTH],
    input logic [WIDTH-1:0] datas [DEPTH],
    input logic [PTR_W-1:0] head,
    input logic [CNT_W-1:0] n
  );
    logic [WIDTH:0]   res;
    logic [PTR_W-1:0] idx;
    res = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if ((CNT_W'(k) < n) && (drs[idx] == sel)) begin
        res = {1'b1, datas[idx]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  wb_queue #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .pop       (we_s),
    .flush     (flush),
    .push_dr   (wb.in_dr),
    .push_data (wb.in_data),
    .ent_dr    (ent_dr_s),
    .ent_data  (ent_data_s),
    .rd_ptr    (rd_ptr_s),
    .count     (count_s)
  );

  // Handshake and write-port gating; flush blocks both sides in its cycle.
  always_comb begin
    ready_s = (count_s != CNT_W'(DEPTH)) & ~flush;
    we_s    = (count_s != {CNT_W{1'b0}}) & ~stall & ~flush;
    push_s  = wb.in_valid & ready_s;
    if (we_s) begin
      bus_s = ent_data_s[rd_ptr_s];
      dr_s  = ent_dr_s[rd_ptr_s];
    end else begin
      bus_s = '0;
      dr_s  = '0;
    end
  end

  assign match_a_s = youngest_match(SR1, ent_dr_s, ent_data_s, rd_ptr_s, count_s);
  assign match_b_s = youngest_match(SR2, ent_dr_s, ent_data_s, rd_ptr_s, count_s);

  assign wb.in_ready = ready_s;
  assign wb.WE       = we_s;
  assign wb.bus      = bus_s;
  assign wb.DR       = dr_s;
  assign hazA        = match_a_s[WIDTH];
  assign fwdA        = match_a_s[WIDTH-1:0];
  assign hazB        = match_b_s[WIDTH];
  assign fwdB        = match_b_s[WIDTH-1:0];
  assign count       = count_s;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: queue-level reference model checked every
// negedge, plus literal expectations taken from hand-worked scenarios.
module tb_reg_writeback;

  localparam int W = 16;
  localparam int D = 4;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         stall = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   SR1   = 3'd0;
  logic [2:0]   SR2   = 3'd0;
  logic         hazA, hazB;
  logic [W-1:0] fwdA, fwdB;
  logic [2:0]   count;

  reg_writeback_if #(.WIDTH(W)) wb ();

  reg_writeback #(.DEPTH(D), .WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wb),
    .stall (stall),
    .flush (flush),
    .SR1   (SR1),
    .SR2   (SR2),
    .hazA  (hazA),
    .hazB  (hazB),
    .fwdA  (fwdA),
    .fwdB  (fwdB),
    .count (count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [2:0]   dr;
    logic [W-1:0] d;
  } ent_t;

  ent_t         mq[$];
  logic [W-1:0] wlog[$];

  // Reference model: an ordered list of pending writes.
  always @(posedge clk or posedge reset) begin : model
    bit do_push;
    bit do_pop;
    if (reset || flush) begin
      mq.delete();
    end else begin
      do_push = wb.in_valid && (mq.size() < D);
      do_pop  = (mq.size() > 0) && !stall;
      if (do_pop) mq.delete(0);
      if (do_push) mq.push_back('{wb.in_dr, wb.in_data});
    end
  end

  // Compare the DUT against the model on every cycle outside reset.
  always @(negedge clk) begin : compare
    logic         ewe, erdy, eha, ehb;
    logic [2:0]   edr;
    logic [W-1:0] ebus, efa, efb;
    if (!reset) begin
      ewe  = (mq.size() > 0) && !stall && !flush;
      erdy = (mq.size() < D) && !flush;
      edr  = ewe ? mq[0].dr : 3'd0;
      ebus = ewe ? mq[0].d : 16'h0000;
      eha = 1'b0; efa = 16'h0000; ehb = 1'b0; efb = 16'h0000;
      foreach (mq[i]) begin
        if (mq[i].dr == SR1) begin eha = 1'b1; efa = mq[i].d; end
        if (mq[i].dr == SR2) begin ehb = 1'b1; efb = mq[i].d; end
      end
      chk("m_we",    wb.WE,       ewe);
      chk("m_ready", wb.in_ready, erdy);
      chk("m_dr",    wb.DR,       edr);
      chk("m_bus",   wb.bus,      ebus);
      chk("m_count", count,       mq.size());
      chk("m_hazA",  hazA,        eha);
      chk("m_fwdA",  fwdA,        efa);
      chk("m_hazB",  hazB,        ehb);
      chk("m_fwdB",  fwdB,        efb);
      if (wb.WE) wlog.push_back(wb.bus);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [2:0] dr, input logic [W-1:0] d);
    wb.in_valid = 1'b1;
    wb.in_dr    = dr;
    wb.in_data  = d;
  endtask

  initial begin
    wb.in_valid = 1'b0;
    wb.in_dr    = 3'd0;
    wb.in_data  = 16'h0000;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_we",    wb.WE,       1'b0);
    chk("rst_bus",   wb.bus,      16'h0000);
    chk("rst_count", count,       3'd0);
    chk("rst_ready", wb.in_ready, 1'b1);
    chk("rst_haz",   {hazA, hazB}, 2'b00);

    // single write, one-cycle latency
    offer(3'd3, 16'h1234);
    cyc();
    wb.in_valid = 1'b0;
    chk("t1_we",  wb.WE,  1'b1);
    chk("t1_dr",  wb.DR,  3'd3);
    chk("t1_bus", wb.bus, 16'h1234);
    cyc();
    chk("t1_we0",   wb.WE, 1'b0);
    chk("t1_count", count, 3'd0);

    // fill while stalled, then drain in order
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(3'(i), 16'hA000 + 16'(i));
      cyc();
    end
    chk("t2_count", count,       3'd4);
    chk("t2_full",  wb.in_ready, 1'b0);
    offer(3'd7, 16'hBEEF);
    cyc();
    chk("t2_refuse", count, 3'd4);
    wb.in_valid = 1'b0;
    stall = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_we",  wb.WE,  1'b1);
      chk("t2_dr",  wb.DR,  3'(i));
      chk("t2_bus", wb.bus, 16'hA000 + 16'(i));
      if (i == 1) chk("t2_ready", wb.in_ready, 1'b1);
      cyc();
    end
    chk("t2_empty", count, 3'd0);

    // duplicate destinations: youngest wins
    stall = 1'b1;
    offer(3'd5, 16'h0001);
    cyc();
    offer(3'd5, 16'h0002);
    cyc();
    wb.in_valid = 1'b0;
    SR1 = 3'd5;
    SR2 = 3'd4;
    #1;
    chk("t3_hazA", hazA, 1'b1);
    chk("t3_fwdA", fwdA, 16'h0002);
    chk("t3_hazB", hazB, 1'b0);
    chk("t3_fwdB", fwdB, 16'h0000);
    stall = 1'b0;
    repeat (2) cyc();
    chk("t3_count", count, 3'd0);
    SR1 = 3'd0;
    SR2 = 3'd0;

    // full queue with in_valid held, then steady push+pop across pointer wrap
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(3'(i), 16'hC000 + 16'(i));
      cyc();
    end
    offer(3'd4, 16'hC004);
    stall = 1'b0;
    wlog.delete();
    #1;
    chk("t4_full_rdy", wb.in_ready, 1'b0);
    chk("t4_full_we",  wb.WE,       1'b1);
    cyc();
    chk("t4_count3", count, 3'd3);
    for (int i = 4; i < 12; i++) begin
      offer(3'(i), 16'hC000 + 16'(i));
      cyc();
      chk("t4_steady", count, 3'd3);
    end
    wb.in_valid = 1'b0;
    repeat (3) cyc();
    chk("t4_drained", count, 3'd0);
    chk("t4_nwrites", wlog.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < wlog.size()) chk("t4_order", wlog[i], 16'hC000 + 16'(i));
    end

    // flush with an offered result
    stall = 1'b1;
    for (int i = 1; i < 4; i++) begin
      offer(3'(i), 16'hD000 + 16'(i));
      cyc();
    end
    offer(3'd6, 16'hDEAD);
    flush = 1'b1;
    stall = 1'b0;
    #1;
    chk("t5_we",    wb.WE,       1'b0);
    chk("t5_ready", wb.in_ready, 1'b0);
    wlog.delete();
    cyc();
    flush = 1'b0;
    wb.in_valid = 1'b0;
    SR1 = 3'd1;
    SR2 = 3'd3;
    #1;
    chk("t5_count", count, 3'd0);
    chk("t5_haz",   {hazA, hazB}, 2'b00);
    repeat (3) cyc();
    chk("t5_nowrite", wlog.size(), 0);

    // asynchronous reset while a write is on the port
    stall = 1'b1;
    offer(3'd2, 16'h5A5A);
    cyc();
    wb.in_valid = 1'b0;
    stall = 1'b0;
    #1;
    chk("t6_we1", wb.WE, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("t6_we",    wb.WE,  1'b0);
    chk("t6_bus",   wb.bus, 16'h0000);
    chk("t6_dr",    wb.DR,  3'd0);
    chk("t6_count", count,  3'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("t6_ready", wb.in_ready, 1'b1);
    chk("t6_after", count,       3'd0);
    repeat (2) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-side sequencer for the 8×16 LC-3b register file. Accepts (destination, value) results from the datapath through a valid/ready handshake, buffers up to DEPTH pending writes in order, and drives the register file write port (bus, WE, DR) one write per cycle. It also reports, for the two register file read selects, whether a buffered write is still pending, and forwards the youngest pending value. It sits between the execute/memory stages and the register file write port, and may be held off by a stall from another bus owner.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- WIDTH, 16, data width.

Ports:
- clk  in  1  single clock; all state on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  a result is offered.
- in_ready  out  1  the queue can take a result this cycle.
- in_dr  in  3  destination register of the offered result.
- in_data  in  WIDTH  value of the offered result.
- stall  in  1  write port is owned elsewhere; suppress writes.
- flush  in  1  discard all pending writes.
- bus  out  WIDTH  register file write data.
- WE  out  1  register file write enable.
- DR  out  3  register file write destination.
- SR1, SR2  in  3  register file read selects, monitored for hazards.
- hazA, hazB  out  1  a pending entry targets SR1 / SR2.
- fwdA, fwdB  out  WIDTH  data of the youngest pending entry matching SR1 / SR2; 0 if there is no match.
- count  out  log2(DEPTH)+1  number of valid entries.

## Operation
- The queue is a circular FIFO with rd_ptr, wr_ptr, and count. Entries hold {dr, data}.
- A push occurs when in_valid & in_ready. Then in_ready = (count != DEPTH) & ~flush, so a push into a full queue is never accepted, even while the queue is popping.
- The write port is combinational from the head entry:
  - WE = (count != 0) & ~stall & ~flush.
  - DR = head.dr and bus = head.data when WE is high; otherwise both are 0.
- A pop occurs whenever WE is high. The register file always captures, so there is no back-pressure beyond stall.
- Push and pop may happen in the same cycle. In that case count is unchanged and both pointers advance.
- Flush has the highest priority. On the next edge count, rd_ptr and wr_ptr all return to 0. No push and no pop occur in the flush cycle.
- Hazard logic:
  - hazA = OR over valid entries of (entry.dr == SR1). hazB is the same with SR2.
  - The head being written this cycle still counts as a hazard, because the register file updates only at the edge.
- Forwarding: fwdA / fwdB take the entry nearest wr_ptr (youngest) among the matches. Duplicate destinations in the queue are legal, and the youngest value wins.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH and never underflows.
- Reset asynchronously sets pointers and count to 0 and clears entry storage to 0. As a result WE = 0, bus = 0, DR = 0, hazA = hazB = 0, fwdA = fwdB = 0, count = 0, and in_ready = 1 once reset deasserts.

## Timing
- Latency from acceptance to register file update:
  - A result accepted at edge N into an empty, unstalled queue makes WE = 1 during cycle N+1.
  - The register file captures it at edge N+1.
- Throughput is one push and one pop per cycle in steady state.
- stall held for k cycles delays every pending write by k cycles. Order is preserved and no entry is lost.
- hazA/hazB and fwdA/fwdB are combinational from the queue state and SR1/SR2, valid in the same cycle.
- Reset mid-operation discards every pending write. No partial write occurs, since WE falls asynchronously.

## Structure
- Shared package: WIDTH and DEPTH defaults, the entry type {dr[2:0], data[WIDTH-1:0]}, and the register-index width constant (3).
- One sub-module, wb_queue: storage, pointers, count, push/pop/flush.
- The top level holds the write-port gating, the two hazard/forward match units (the same function instanced twice), and the handshake.

## Test plan
1. Reset, then push {dr=3, data=16'h1234} → in the next cycle WE=1, DR=3, bus=16'h1234. In the cycle after that, WE=0 and count=0.
2. stall=1, then push dr=0..3 with data 16'hA000..16'hA003 → count=4 and in_ready=0, and a 5th push is refused. Release stall → four consecutive writes in order, and in_ready=1 after the first pop.
3. stall=1, push {5,16'h0001} then {5,16'h0002}, SR1=5, SR2=4 → hazA=1, fwdA=16'h0002, hazB=0, fwdB=0.
4. Full queue with stall=0 and in_valid held high → no push in the full cycle. Then steady push+pop with count=3, and data order is preserved across pointer wrap (≥10 entries total).
5. Three entries pending with flush=1 and in_valid=1 → WE=0 and in_ready=0 that cycle. On the next cycle count=0, hazA=hazB=0, and no writes ever appear.
6. Assert reset asynchronously mid-cycle with WE=1 → WE, bus, DR and count go to 0 immediately, before the next edge.
